muxes_tdm: RTL and testbench

Parametrised, single-clock successor to the phy_tx lane multiplexer. It time-division multiplexes `LANES` input lanes of `DATA_W` bits, each with a valid flag, onto one output stream. An internal slot counter replaces the divided clock tree. It emits a frame marker and lane index, and optionally substitutes an idle symbol in empty slots. It sits between the per-lane byte sources and the serializer/line coder in phy_tx.

---
 rtl/muxes_tdm.sv | 116 +++++++++++
 tb/tb_muxes_tdm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muxes_tdm.sv
// muxes_tdm: time-division multiplexer for the phy_tx lane path.
// Collects LANES parallel lanes of DATA_W bits, each with a valid flag,
// once per frame. It then emits them one lane per cycle on a single
// output stream. A free-running slot counter sets the frame timing.
//
// Optional feature (compile-time macro MUXES_TDM_IDLE_FILL_EN):
//   defined   - invalid slots output IDLE_SYM.
//   undefined - invalid slots output the lane's held data.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   in_data     LANES*DATA_W lane data; lane i at [i*DATA_W +: DATA_W]
//   in_valid    per-lane valid flag
//   in_take     high in the cycle whose closing edge samples all lanes
//   out_data    multiplexed data of the current slot
//   out_valid   valid flag of the current slot
//   out_lane    lane index of the current slot
//   frame_start high on lane 0 of every captured frame
module muxes_tdm #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       LANES    = 4,
    parameter logic [DATA_W-1:0] IDLE_SYM = DATA_W'(8'hBC)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES*DATA_W-1:0]    in_data,
    input  logic [LANES-1:0]           in_valid,
    output logic                       in_take,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    output logic [$clog2(LANES)-1:0]   out_lane,
    output logic                       frame_start
);

    localparam int unsigned      CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LANES - 1);

`ifdef MUXES_TDM_IDLE_FILL_EN
    localparam bit IDLE_FILL = 1'b1;
`else
    localparam bit IDLE_FILL = 1'b0;
`endif

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LANES-1:0]  cap_valid_q, cap_valid_d;
    logic [DATA_W-1:0] cap_data_q [LANES];
    logic [DATA_W-1:0] cap_data_d [LANES];
    logic              primed_q, primed_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  out_lane_q, out_lane_d;
    logic              frame_start_q, frame_start_d;
    logic              take_c;

    // Slot counter, capture bank and output stage next-state.
    // The output stage reads the *current* capture contents. The last slot
    // of a frame is therefore emitted from the old bank on the same edge
    // that loads the new frame.
    always_comb begin
        cnt_d         = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        take_c        = (cnt_q == LAST);
        cap_valid_d   = cap_valid_q;
        cap_data_d    = cap_data_q;
        primed_d      = primed_q | take_c;

        if (take_c) begin
            for (int i = 0; i < LANES; i++) begin
                cap_valid_d[i] = in_valid[i];
                // Invalid lanes keep their previous data; only the flag drops.
                if (in_valid[i]) begin
                    cap_data_d[i] = in_data[i*DATA_W +: DATA_W];
                end
            end
        end

        out_lane_d    = cnt_q;
        out_valid_d   = cap_valid_q[cnt_q];
        out_data_d    = (IDLE_FILL && !cap_valid_q[cnt_q]) ? IDLE_SYM
                                                           : cap_data_q[cnt_q];
        // primed masks the garbage-free but empty first frame after reset.
        frame_start_d = (cnt_q == '0) && primed_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            cap_valid_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                cap_data_q[i] <= '0;
            end
            primed_q      <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_lane_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            cap_valid_q   <= cap_valid_d;
            cap_data_q    <= cap_data_d;
            primed_q      <= primed_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_lane_q    <= out_lane_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign in_take     = take_c;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_lane    = out_lane_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_muxes_tdm.sv
// Testbench for muxes_tdm: table-driven frames, a sampling-window sequence,
// a mid-frame reset, and randomized runs on LANES=4/2/8/16 against a
// slot-by-slot reference model.
module tb_muxes_tdm;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // inst 0: LANES=4 DATA_W=8
    logic [31:0]  d0_in_data;
    logic [3:0]   d0_in_valid;
    logic         d0_in_take, d0_out_valid, d0_fs;
    logic [7:0]   d0_out_data;
    logic [1:0]   d0_out_lane;
    // inst 1: LANES=2 DATA_W=10
    logic [19:0]  d1_in_data;
    logic [1:0]   d1_in_valid;
    logic         d1_in_take, d1_out_valid, d1_fs;
    logic [9:0]   d1_out_data;
    logic [0:0]   d1_out_lane;
    // inst 2: LANES=8 DATA_W=10
    logic [79:0]  d2_in_data;
    logic [7:0]   d2_in_valid;
    logic         d2_in_take, d2_out_valid, d2_fs;
    logic [9:0]   d2_out_data;
    logic [2:0]   d2_out_lane;
    // inst 3: LANES=16 DATA_W=10
    logic [159:0] d3_in_data;
    logic [15:0]  d3_in_valid;
    logic         d3_in_take, d3_out_valid, d3_fs;
    logic [9:0]   d3_out_data;
    logic [3:0]   d3_out_lane;

    muxes_tdm u0 (
        .clk(clk), .reset(reset), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_take(d0_in_take), .out_data(d0_out_data), .out_valid(d0_out_valid),
        .out_lane(d0_out_lane), .frame_start(d0_fs)
    );
    muxes_tdm #(.DATA_W(10), .LANES(2)) u1 (
        .clk(clk), .reset(reset), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_take(d1_in_take), .out_data(d1_out_data), .out_valid(d1_out_valid),
        .out_lane(d1_out_lane), .frame_start(d1_fs)
    );
    muxes_tdm #(.DATA_W(10), .LANES(8)) u2 (
        .clk(clk), .reset(reset), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .in_take(d2_in_take), .out_data(d2_out_data), .out_valid(d2_out_valid),
        .out_lane(d2_out_lane), .frame_start(d2_fs)
    );
    muxes_tdm #(.DATA_W(10), .LANES(16)) u3 (
        .clk(clk), .reset(reset), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_take(d3_in_take), .out_data(d3_out_data), .out_valid(d3_out_valid),
        .out_lane(d3_out_lane), .frame_start(d3_fs)
    );

`ifdef MUXES_TDM_IDLE_FILL_EN
    localparam bit IDLE_FILL = 1'b1;
`else
    localparam bit IDLE_FILL = 1'b0;
`endif
    localparam logic [9:0] IDLE = 10'h0BC;

    int checks;
    int errors;

    // Reference model: cycles since reset, the frame snapshot held per lane.
    int         m_t      [4];
    bit         m_known  [4];
    bit         m_primed [4];
    logic [9:0] m_snap_d [4][16];
    logic       m_snap_v [4][16];

    typedef struct {
        logic [31:0] din;
        logic [3:0]  vin;
        logic [31:0] exp_d;
        logic [3:0]  exp_v;
    } vec_t;
    vec_t tbl [4];

    task automatic drive_in(input int inst, input logic [159:0] d, input logic [15:0] v);
        case (inst)
            0: begin d0_in_data = d[31:0];  d0_in_valid = v[3:0];  end
            1: begin d1_in_data = d[19:0];  d1_in_valid = v[1:0];  end
            2: begin d2_in_data = d[79:0];  d2_in_valid = v[7:0];  end
            default: begin d3_in_data = d;  d3_in_valid = v;       end
        endcase
    endtask

    task automatic get_out(input int inst, output logic tk, output logic [9:0] od,
                           output logic ov, output logic [3:0] ol, output logic fs);
        case (inst)
            0: begin tk = d0_in_take; od = 10'(d0_out_data); ov = d0_out_valid;
                     ol = 4'(d0_out_lane); fs = d0_fs; end
            1: begin tk = d1_in_take; od = d1_out_data; ov = d1_out_valid;
                     ol = 4'(d1_out_lane); fs = d1_fs; end
            2: begin tk = d2_in_take; od = d2_out_data; ov = d2_out_valid;
                     ol = 4'(d2_out_lane); fs = d2_fs; end
            default: begin tk = d3_in_take; od = d3_out_data; ov = d3_out_valid;
                     ol = d3_out_lane; fs = d3_fs; end
        endcase
    endtask

    // One clock cycle: drive inputs, check in_take, advance model, check outputs.
    task automatic cycle_check(input int inst, input int L, input int DW,
                               input logic [159:0] d, input logic [15:0] v, input logic rst);
        logic tk, ov, fs, ev, efs, etk;
        logic [9:0] od, ed;
        logic [3:0] ol, el;
        int lane;
        @(negedge clk);
        reset = rst;
        drive_in(inst, d, v);
        #1;
        if (m_known[inst]) begin
            get_out(inst, tk, od, ov, ol, fs);
            etk = ((m_t[inst] % L) == L - 1);
            checks++;
            if (tk !== etk) begin
                errors++;
                $display("FAIL in_take inst%0d t=%0d got %0b want %0b", inst, m_t[inst], tk, etk);
            end
        end
        if (rst) begin
            ed = '0; ev = 1'b0; el = '0; efs = 1'b0;
            m_t[inst] = 0; m_primed[inst] = 1'b0; m_known[inst] = 1'b1;
            for (int i = 0; i < 16; i++) begin
                m_snap_d[inst][i] = '0;
                m_snap_v[inst][i] = 1'b0;
            end
        end else begin
            lane = m_t[inst] % L;
            ev   = m_snap_v[inst][lane];
            ed   = (IDLE_FILL && !ev) ? IDLE : m_snap_d[inst][lane];
            el   = 4'(lane);
            efs  = (lane == 0) && m_primed[inst];
            if (lane == L - 1) begin
                for (int i = 0; i < L; i++) begin
                    m_snap_v[inst][i] = v[i];
                    if (v[i]) begin
                        for (int b = 0; b < DW; b++) m_snap_d[inst][i][b] = d[i*DW + b];
                    end
                end
                m_primed[inst] = 1'b1;
            end
            m_t[inst]++;
        end
        @(posedge clk);
        #1;
        get_out(inst, tk, od, ov, ol, fs);
        checks++;
        if ({od, ov, ol, fs} !== {ed, ev, el, efs}) begin
            errors++;
            $display("FAIL model inst%0d rst=%0b got d=%h v=%0b l=%0d fs=%0b want d=%h v=%0b l=%0d fs=%0b",
                     inst, rst, od, ov, ol, fs, ed, ev, el, efs);
        end
    endtask

    function automatic logic [159:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic tk, ov, fs;
        logic [9:0] od;
        logic [3:0] ol;
        logic [159:0] d;
        logic [15:0] v;
        int L;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_in(k, '0, '0);
            m_known[k] = 1'b0;
        end

        tbl[0] = '{32'h44332211, 4'b1111, 32'h44332211, 4'b1111};
        tbl[1] = '{32'hDDCCBBAA, 4'b1010, IDLE_FILL ? 32'hDDBCBBBC : 32'hDD33BB11, 4'b1010};
        tbl[2] = '{32'h5A5A5A5A, 4'b0000, IDLE_FILL ? 32'hBCBCBCBC : 32'hDD33BB11, 4'b0000};
        tbl[3] = '{32'h04030201, 4'b0101, IDLE_FILL ? 32'hBC03BC01 : 32'hDD03BB01, 4'b0101};

        // Reset for 3 cycles, then table frames with noise between captures.
        repeat (3) cycle_check(0, 4, 8, rnd_data(), 16'($urandom), 1'b1);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 3 && r < 4) cycle_check(0, 4, 8, 160'(tbl[r].din), 16'(tbl[r].vin), 1'b0);
                else                 cycle_check(0, 4, 8, rnd_data(), 16'($urandom), 1'b0);
                get_out(0, tk, od, ov, ol, fs);
                checks++;
                if (r == 0) begin
                    if ({ov, fs, od} !== {1'b0, 1'b0, (IDLE_FILL ? IDLE : 10'h000)}) begin
                        errors++;
                        $display("FAIL first_frame slot%0d got v=%0b fs=%0b d=%h", c, ov, fs, od);
                    end
                end else if ({od[7:0], ov, ol[1:0], fs} !==
                             {tbl[r-1].exp_d[c*8 +: 8], tbl[r-1].exp_v[c], 2'(c), (c == 0)}) begin
                    errors++;
                    $display("FAIL table rec%0d slot%0d got d=%h v=%0b l=%0d fs=%0b want d=%h v=%0b",
                             r - 1, c, od[7:0], ov, ol, fs, tbl[r-1].exp_d[c*8 +: 8], tbl[r-1].exp_v[c]);
                end
            end
        end

        // Sampling window: data changes every cycle; only the take-cycle value counts.
        for (int c = 0; c < 4; c++) begin
            d = (c == 3) ? 160'h87654321 : 160'({8{c[3:0]}} ^ 32'hFFFFFFFF);
            cycle_check(0, 4, 8, d, 16'hF, 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            cycle_check(0, 4, 8, rnd_data(), 16'hF, 1'b0);
            get_out(0, tk, od, ov, ol, fs);
            d = 160'h87654321;
            checks++;
            if ({od[7:0], ov} !== {d[c*8 +: 8], 1'b1}) begin
                errors++;
                $display("FAIL window slot%0d got d=%h v=%0b want d=%h", c, od[7:0], ov, d[c*8 +: 8]);
            end
        end

        // Mid-frame reset right after lane 2 has been emitted.
        for (int n = 0; n < 8; n++) begin
            cycle_check(0, 4, 8, rnd_data(), 16'hF, 1'b0);
            if (((m_t[0] - 1) % 4) == 2) break;
        end
        cycle_check(0, 4, 8, rnd_data(), 16'hF, 1'b1);
        get_out(0, tk, od, ov, ol, fs);
        checks++;
        if ({od, ov, ol, fs} !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got d=%h v=%0b l=%0d fs=%0b want all 0", od, ov, ol, fs);
        end
        repeat (12) cycle_check(0, 4, 8, rnd_data(), 16'hF, 1'b0);

        // Randomized runs with occasional resets on every lane count.
        for (int inst = 0; inst < 4; inst++) begin
            L = (inst == 0) ? 4 : (inst == 1) ? 2 : (inst == 2) ? 8 : 16;
            m_known[inst] = 1'b0;
            repeat (2) cycle_check(inst, L, (inst == 0) ? 8 : 10, rnd_data(), 16'($urandom), 1'b1);
            for (int n = 0; n < 40 * L; n++) begin
                v = 16'($urandom);
                cycle_check(inst, L, (inst == 0) ? 8 : 10, rnd_data(), v,
                            ($urandom_range(0, 70) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
